// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// riscv_ctrl_pkg : state encoding and defaults shared by the fetch controller
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    localparam int STATE_W         = 3;
    localparam int TIMER_W         = 8;
    localparam int MEM_TIMEOUT_DEF = 15;

    localparam logic [STATE_W-1:0] c_st_idle      = 3'd0;
    localparam logic [STATE_W-1:0] c_st_fetch     = 3'd1;
    localparam logic [STATE_W-1:0] c_st_decode    = 3'd2;
    localparam logic [STATE_W-1:0] c_st_execute   = 3'd3;
    localparam logic [STATE_W-1:0] c_st_writeback = 3'd4;
    localparam logic [STATE_W-1:0] c_st_update    = 3'd5;
    localparam logic [STATE_W-1:0] c_st_halt      = 3'd6;
    localparam logic [STATE_W-1:0] c_st_fault     = 3'd7;

endpackage

`default_nettype wire

// File: rtl/riscv_wait_timer.sv
// ============================================================================
// riscv_wait_timer : clearable saturating counter, flags the step onto LIMIT
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_wait_timer #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             expire
);

    localparam logic [WIDTH-1:0] c_limit    = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] c_limit_m1 = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // expire fires in the cycle whose increment lands on LIMIT
    assign expire = inc && (r_count == c_limit_m1);
    assign count  = r_count;

endmodule

`default_nettype wire

// File: rtl/riscv_fetch_ctrl.sv
// ============================================================================
// riscv_fetch_ctrl : multi-cycle fetch/decode/execute sequencing controller
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_fetch_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             imem_ready,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic             is_halt,
    input  logic             wb_req,
    output logic             pc_en,
    output logic             pc_src,
    output logic             prev_pc_en,
    output logic             imem_req,
    output logic             ir_en,
    output logic             rf_we,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               r_branch;
    logic [CNT_W-1:0]   r_retired;
    logic [TIMER_W-1:0] w_wait_count;
    logic               w_wait_expire;
    logic               w_wait_clear;
    logic               w_wait_inc;

    // Counter sits at zero outside FETCH, so every FETCH entry starts fresh
    assign w_wait_clear = (r_state != c_st_fetch);
    assign w_wait_inc   = (r_state == c_st_fetch) && !imem_ready;

    riscv_wait_timer #(
        .WIDTH (TIMER_W),
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_wait_clear),
        .inc    (w_wait_inc),
        .count  (w_wait_count),
        .expire (w_wait_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:      if (run) w_next_state = c_st_fetch;
            c_st_fetch: begin
                if (imem_ready)         w_next_state = c_st_decode;
                else if (w_wait_expire) w_next_state = c_st_fault;
            end
            c_st_decode:    w_next_state = c_st_execute;
            c_st_execute: begin
                if (is_halt)     w_next_state = c_st_halt;
                else if (wb_req) w_next_state = c_st_writeback;
                else             w_next_state = c_st_update;
            end
            c_st_writeback: w_next_state = c_st_update;
            c_st_update:    w_next_state = run ? c_st_fetch : c_st_idle;
            c_st_halt:      w_next_state = c_st_halt;
            c_st_fault:     w_next_state = c_st_fault;
            default:        w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        prev_pc_en = 1'b0;
        imem_req   = 1'b0;
        ir_en      = 1'b0;
        rf_we      = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (r_state)
            c_st_fetch: begin
                busy       = 1'b1;
                imem_req   = 1'b1;
                prev_pc_en = (w_wait_count == '0);
                ir_en      = imem_ready;
            end
            c_st_decode, c_st_execute: busy = 1'b1;
            c_st_writeback: begin
                busy  = 1'b1;
                rf_we = 1'b1;
            end
            c_st_update: begin
                busy   = 1'b1;
                pc_en  = 1'b1;
                pc_src = r_branch;
            end
            c_st_halt:  halted = 1'b1;
            c_st_fault: fault  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branch  <= 1'b0;
            r_retired <= '0;
        end else begin
            if (r_state == c_st_execute) r_branch  <= is_branch && branch_taken;
            if (r_state == c_st_update)  r_retired <= r_retired + 1'b1;
        end
    end

    assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_riscv_fetch_ctrl.sv
// ============================================================================
// tb_riscv_fetch_ctrl : cycle-by-cycle vector bench for riscv_fetch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_fetch_ctrl;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n, run, imem_ready, is_branch, branch_taken, is_halt, wb_req;
    logic             pc_en, pc_src, prev_pc_en, imem_req, ir_en, rf_we, busy, halted, fault;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_fetch_ctrl #(
        .MEM_TIMEOUT (15),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_ready   (imem_ready),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .is_halt      (is_halt),
        .wb_req       (wb_req),
        .pc_en        (pc_en),
        .pc_src       (pc_src),
        .prev_pc_en   (prev_pc_en),
        .imem_req     (imem_req),
        .ir_en        (ir_en),
        .rf_we        (rf_we),
        .busy         (busy),
        .halted       (halted),
        .fault        (fault),
        .retired      (retired)
    );

    // {pc_en, pc_src, prev_pc_en, imem_req, ir_en, rf_we, busy, halted, fault}
    localparam logic [8:0] E_IDLE  = 9'b000000000;
    localparam logic [8:0] E_FRDY  = 9'b001110100;
    localparam logic [8:0] E_FW1   = 9'b001100100;
    localparam logic [8:0] E_FWN   = 9'b000100100;
    localparam logic [8:0] E_FLATE = 9'b000110100;
    localparam logic [8:0] E_BUSY  = 9'b000000100;
    localparam logic [8:0] E_WB    = 9'b000001100;
    localparam logic [8:0] E_UPD0  = 9'b100000100;
    localparam logic [8:0] E_UPD1  = 9'b110000100;
    localparam logic [8:0] E_HALT  = 9'b000000010;
    localparam logic [8:0] E_FAULT = 9'b000000001;

    typedef struct {
        logic             rs;
        logic             run;
        logic             rdy;
        logic             br;
        logic             tk;
        logic             hlt;
        logic             wb;
        logic [8:0]       exp;
        logic [CNT_W-1:0] ret;
        string            name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rs, input logic rn, input logic rdy,
                                input logic br, input logic tk, input logic hlt,
                                input logic wb, input logic [8:0] exp,
                                input logic [CNT_W-1:0] ret, input string name);
        vec_t v;
        v.rs = rs; v.run = rn; v.rdy = rdy; v.br = br; v.tk = tk;
        v.hlt = hlt; v.wb = wb; v.exp = exp; v.ret = ret; v.name = name;
        tbl.push_back(v);
    endfunction

    // One full instruction with memory ready immediately, run held high
    function automatic void add_instr(input logic wb, input logic br, input logic tk,
                                      input logic run_upd, input logic [CNT_W-1:0] ret,
                                      input string name);
        add(1, 1, 1, 0, 0, 0, 0, E_FRDY, ret, {name, "_fetch"});
        add(1, 1, 1, 0, 0, 0, 0, E_BUSY, ret, {name, "_decode"});
        add(1, 1, 1, br, tk, 0, wb, E_BUSY, ret, {name, "_execute"});
        if (wb) add(1, 1, 1, 0, 0, 0, 0, E_WB, ret, {name, "_writeback"});
        add(1, run_upd, 1, 0, 0, 0, 0, (br && tk) ? E_UPD1 : E_UPD0, ret, {name, "_update"});
    endfunction

    task automatic apply(input vec_t v);
        logic [8:0] act;
        @(negedge clk);
        rst_n = v.rs; run = v.run; imem_ready = v.rdy;
        is_branch = v.br; branch_taken = v.tk; is_halt = v.hlt; wb_req = v.wb;
        #1;
        act = {pc_en, pc_src, prev_pc_en, imem_req, ir_en, rf_we, busy, halted, fault};
        checks++;
        if (act !== v.exp || retired !== v.ret) begin
            errors++;
            $display("FAIL %s @%0t: outputs %b retired %0d, required %b retired %0d",
                     v.name, $time, act, retired, v.exp, v.ret);
        end
    endtask

    task automatic flush();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; is_branch = 1'b0;
        branch_taken = 1'b0; is_halt = 1'b0; wb_req = 1'b0;
        repeat (2) @(posedge clk);

        // Vector table: back-to-back instructions, writeback, branches
        add(1, 0, 0, 0, 0, 0, 0, E_IDLE, 0, "reset_idle");
        add(1, 1, 0, 0, 0, 0, 0, E_IDLE, 0, "idle_run");
        add_instr(1, 0, 0, 1, 0, "wb_i1");
        add_instr(1, 0, 0, 1, 1, "wb_i2");
        add_instr(1, 0, 0, 1, 2, "wb_i3");
        add_instr(0, 1, 1, 1, 3, "br_taken");
        add_instr(0, 1, 0, 0, 4, "br_untaken");
        add(1, 0, 0, 0, 0, 0, 0, E_IDLE, 5, "idle_after_stop");
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();

        // 14 wait cycles then ready: normal completion
        add(1, 1, 0, 0, 0, 0, 0, E_IDLE, 5, "idle_to_fetch");
        add(1, 1, 0, 0, 0, 0, 0, E_FW1, 5, "wait14_first");
        for (int i = 0; i < 13; i++) add(1, 1, 0, 0, 0, 0, 0, E_FWN, 5, "wait14");
        add(1, 1, 1, 0, 0, 0, 0, E_FLATE, 5, "wait14_ready");
        add(1, 1, 1, 0, 0, 0, 0, E_BUSY, 5, "wait14_decode");
        add(1, 1, 1, 0, 0, 0, 0, E_BUSY, 5, "wait14_execute");
        add(1, 1, 1, 0, 0, 0, 0, E_UPD0, 5, "wait14_update");
        // 15 wait cycles: fault, sticky
        add(1, 1, 0, 0, 0, 0, 0, E_FW1, 6, "wait15_first");
        for (int i = 0; i < 14; i++) add(1, 1, 0, 0, 0, 0, 0, E_FWN, 6, "wait15");
        for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 0, 0, E_FAULT, 6, "fault_hold");
        flush();

        // Reset out of FAULT, then halt with a pending writeback
        add(0, 1, 1, 0, 0, 0, 0, E_FAULT, 6, "reset_in_fault");
        add(1, 1, 1, 0, 0, 0, 0, E_IDLE, 0, "post_fault_reset");
        add_instr(0, 0, 0, 1, 0, "pre_halt");
        add(1, 1, 1, 0, 0, 0, 0, E_FRDY, 1, "halt_fetch");
        add(1, 1, 1, 0, 0, 0, 0, E_BUSY, 1, "halt_decode");
        add(1, 1, 1, 0, 0, 1, 1, E_BUSY, 1, "halt_execute");
        for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 0, 0, 1, E_HALT, 1, "halt_hold");
        flush();

        // Reset from HALT, then reset in the middle of WRITEBACK
        add(0, 1, 1, 0, 0, 0, 0, E_HALT, 1, "reset_in_halt");
        add(1, 1, 1, 0, 0, 0, 0, E_IDLE, 0, "post_halt_reset");
        add_instr(0, 0, 0, 1, 0, "pre_wb_reset");
        add(1, 1, 1, 0, 0, 0, 0, E_FRDY, 1, "wbrst_fetch");
        add(1, 1, 1, 0, 0, 0, 0, E_BUSY, 1, "wbrst_decode");
        add(1, 1, 1, 0, 0, 0, 1, E_BUSY, 1, "wbrst_execute");
        add(0, 1, 1, 0, 0, 0, 0, E_WB, 1, "reset_in_wb");
        add(1, 0, 1, 0, 0, 0, 0, E_IDLE, 0, "post_wb_reset");
        flush();

        // run dropped in DECODE: instruction finishes, then IDLE, then resume
        add(1, 1, 1, 0, 0, 0, 0, E_IDLE, 0, "rundrop_idle");
        add(1, 1, 1, 0, 0, 0, 0, E_FRDY, 0, "rundrop_fetch");
        add(1, 0, 1, 0, 0, 0, 0, E_BUSY, 0, "rundrop_decode");
        add(1, 0, 1, 0, 0, 0, 1, E_BUSY, 0, "rundrop_execute");
        add(1, 0, 1, 0, 0, 0, 0, E_WB, 0, "rundrop_wb");
        add(1, 0, 1, 0, 0, 0, 0, E_UPD0, 0, "rundrop_update");
        add(1, 0, 1, 0, 0, 0, 0, E_IDLE, 1, "rundrop_stopped");
        add(1, 1, 1, 0, 0, 0, 0, E_IDLE, 1, "rundrop_resume");
        // retired counter wraps from 7 to 0
        for (int i = 1; i < 8; i++) add_instr(0, 0, 0, 1, CNT_W'(i), "wrap_instr");
        add(1, 1, 1, 0, 0, 0, 0, E_FRDY, 0, "retired_wrap");
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
